// File: rtl/rgb_to_gray_stream.sv
// Streaming RGB-to-gray converter: three registered stages (expand, multiply/compare,
// round/pack) with valid/ready handshakes and bubble-collapsing stalls.
module rgb_to_gray_stream #(
   parameter int unsigned R_W   = 5,
   parameter int unsigned G_W   = 6,
   parameter int unsigned B_W   = 5,
   parameter int unsigned OUT_W = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [R_W+G_W+B_W-1:0]   i_rgb,
   input  logic [1:0]               i_mode,
   input  logic                     i_valid,
   output logic                     o_ready,
   output logic [OUT_W-1:0]         o_gray,
   output logic [15:0]              o_gray_rgb565,
   output logic                     o_valid,
   input  logic                     i_ready
);

   localparam int unsigned PixW = R_W + G_W + B_W;

   localparam logic [1:0] ModeLuma  = 2'd0;
   localparam logic [1:0] ModeAvg   = 2'd1;
   localparam logic [1:0] ModeMax   = 2'd2;
   localparam logic [1:0] ModeGreen = 2'd3;

   // Stage 1: expanded channels
   logic       s1_valid_q, s1_valid_d;
   logic [7:0] s1_r_q, s1_r_d;
   logic [7:0] s1_g_q, s1_g_d;
   logic [7:0] s1_b_q, s1_b_d;
   logic [1:0] s1_mode_q, s1_mode_d;

   // Stage 2: un-shifted accumulator (products + rounding constant, or plain 8-bit value)
   logic        s2_valid_q, s2_valid_d;
   logic [17:0] s2_acc_q, s2_acc_d;
   logic [1:0]  s2_mode_q, s2_mode_d;

   // Stage 3: final outputs
   logic             s3_valid_q, s3_valid_d;
   logic [OUT_W-1:0] s3_gray_q, s3_gray_d;
   logic [15:0]      s3_rgb565_q, s3_rgb565_d;

   logic s1_adv, s2_adv, s3_adv;

   logic [R_W-1:0] r_in;
   logic [G_W-1:0] g_in;
   logic [B_W-1:0] b_in;
   logic [7:0]     r8, g8, b8;

   // Handshake control: a stage loads when it is empty or its successor moves on
   always_comb begin
      s3_adv  = !s3_valid_q || i_ready;
      s2_adv  = !s2_valid_q || s3_adv;
      s1_adv  = !s1_valid_q || s2_adv;
      o_ready = s1_adv;
      o_valid = s3_valid_q;
      o_gray  = s3_gray_q;
      o_gray_rgb565 = s3_rgb565_q;
   end

   // Expand each channel to 8 bits by cyclic MSB replication (identity at width 8)
   always_comb begin
      r_in = i_rgb[PixW-1 -: R_W];
      g_in = i_rgb[G_W+B_W-1 -: G_W];
      b_in = i_rgb[B_W-1:0];
      r8   = '0;
      g8   = '0;
      b8   = '0;
      for (int i = 0; i < 8; i++) begin
         r8[7-i] = r_in[R_W-1-(i%R_W)];
         g8[7-i] = g_in[G_W-1-(i%G_W)];
         b8[7-i] = b_in[B_W-1-(i%B_W)];
      end
   end

   // Stage 1 next state
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_r_d     = s1_r_q;
      s1_g_d     = s1_g_q;
      s1_b_d     = s1_b_q;
      s1_mode_d  = s1_mode_q;
      if (s1_adv) begin
         s1_valid_d = i_valid;
         if (i_valid) begin
            s1_r_d    = r8;
            s1_g_d    = g8;
            s1_b_d    = b8;
            s1_mode_d = i_mode;
         end
      end
   end

   logic [9:0]  sum3;
   logic [7:0]  max_rg, max_rgb;
   logic [17:0] acc_calc;

   // Stage 2 next state: weighted sums with rounding constants, or compare/select
   always_comb begin
      sum3     = {2'b00, s1_r_q} + {2'b00, s1_g_q} + {2'b00, s1_b_q};
      max_rg   = (s1_r_q > s1_g_q) ? s1_r_q : s1_g_q;
      max_rgb  = (max_rg > s1_b_q) ? max_rg : s1_b_q;
      acc_calc = '0;
      unique case (s1_mode_q)
         ModeLuma:  acc_calc = {10'd0, s1_r_q} * 18'd77 + {10'd0, s1_g_q} * 18'd150
                               + {10'd0, s1_b_q} * 18'd29 + 18'd128;
         ModeAvg:   acc_calc = {8'd0, sum3} * 18'd171 + 18'd256;
         ModeMax:   acc_calc = {10'd0, max_rgb};
         ModeGreen: acc_calc = {10'd0, s1_g_q};
         default:   acc_calc = '0;
      endcase
      s2_valid_d = s2_valid_q;
      s2_acc_d   = s2_acc_q;
      s2_mode_d  = s2_mode_q;
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_acc_d  = acc_calc;
            s2_mode_d = s1_mode_q;
         end
      end
   end

   logic [17:0] shifted;
   logic [7:0]  gray8;

   // Stage 3 next state: normalise, saturate, truncate and re-pack
   always_comb begin
      unique case (s2_mode_q)
         ModeLuma: shifted = s2_acc_q >> 8;
         ModeAvg:  shifted = s2_acc_q >> 9;
         default:  shifted = s2_acc_q;
      endcase
      gray8       = (shifted > 18'd255) ? 8'hFF : shifted[7:0];
      s3_valid_d  = s3_valid_q;
      s3_gray_d   = s3_gray_q;
      s3_rgb565_d = s3_rgb565_q;
      if (s3_adv) begin
         s3_valid_d = s2_valid_q;
         if (s2_valid_q) begin
            s3_gray_d   = gray8[7 -: OUT_W];
            s3_rgb565_d = {gray8[7:3], gray8[7:2], gray8[7:3]};
         end
      end
   end

   // Pipeline registers with synchronous reset; data cleared so outputs read zero
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_valid_q  <= 1'b0;
         s1_r_q      <= '0;
         s1_g_q      <= '0;
         s1_b_q      <= '0;
         s1_mode_q   <= '0;
         s2_valid_q  <= 1'b0;
         s2_acc_q    <= '0;
         s2_mode_q   <= '0;
         s3_valid_q  <= 1'b0;
         s3_gray_q   <= '0;
         s3_rgb565_q <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_r_q      <= s1_r_d;
         s1_g_q      <= s1_g_d;
         s1_b_q      <= s1_b_d;
         s1_mode_q   <= s1_mode_d;
         s2_valid_q  <= s2_valid_d;
         s2_acc_q    <= s2_acc_d;
         s2_mode_q   <= s2_mode_d;
         s3_valid_q  <= s3_valid_d;
         s3_gray_q   <= s3_gray_d;
         s3_rgb565_q <= s3_rgb565_d;
      end
   end

endmodule

// File: tb/tb_rgb_to_gray_stream.sv
// Scoreboard bench for rgb_to_gray_stream: driver pushes expected results on accept,
// monitor pops and compares on every output transfer.
module tb_rgb_to_gray_stream;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] i_rgb;
   logic [1:0]  i_mode;
   logic        i_valid;
   logic        o_ready;
   logic [7:0]  o_gray;
   logic [15:0] o_565;
   logic        o_valid;
   logic        i_ready;

   // Secondary instances for parameter corner cases
   logic [15:0] rgb4;
   logic [1:0]  mode4;
   logic [23:0] rgb8;
   logic [1:0]  mode8;
   logic        one;
   logic        rdy4_o, val4_o, rdy8_o, val8_o;
   logic [3:0]  gray4;
   logic [15:0] c565_4, c565_8;
   logic [7:0]  gray8;

   rgb_to_gray_stream u_dut (
      .i_clk(clk), .i_rst(rst), .i_rgb(i_rgb), .i_mode(i_mode), .i_valid(i_valid),
      .o_ready(o_ready), .o_gray(o_gray), .o_gray_rgb565(o_565), .o_valid(o_valid),
      .i_ready(i_ready)
   );

   rgb_to_gray_stream #(.OUT_W(4)) u_dut4 (
      .i_clk(clk), .i_rst(rst), .i_rgb(rgb4), .i_mode(mode4), .i_valid(one),
      .o_ready(rdy4_o), .o_gray(gray4), .o_gray_rgb565(c565_4), .o_valid(val4_o),
      .i_ready(one)
   );

   rgb_to_gray_stream #(.R_W(8), .G_W(8), .B_W(8)) u_dut8 (
      .i_clk(clk), .i_rst(rst), .i_rgb(rgb8), .i_mode(mode8), .i_valid(one),
      .o_ready(rdy8_o), .o_gray(gray8), .o_gray_rgb565(c565_8), .o_valid(val8_o),
      .i_ready(one)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      logic [7:0]  gray;
      logic [15:0] c565;
      int          acc;
   } exp_t;

   exp_t        sb[$];
   int          pop_hist[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          pop_cnt = 0;
   int          rdy_mode = 0;
   bit          lat_chk = 0;

   logic [15:0] vec_rgb[16];
   logic [1:0]  vec_mode[16];
   logic [7:0]  vec_gray[16];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] pack565(input logic [7:0] g);
      return {g[7:3], g[7:2], g[7:3]};
   endfunction

   // i_ready driver: 0 = always ready, 1 = stalled, 2 = random
   initial forever begin
      @(negedge clk);
      case (rdy_mode)
         0:       i_ready = 1'b1;
         1:       i_ready = 1'b0;
         default: i_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: samples one time unit before each rising edge
   initial begin : monitor
      exp_t        e;
      bit          hold_v;
      logic [7:0]  hold_gray;
      logic [15:0] hold_565;
      hold_v = 0;
      forever begin
         @(negedge clk);
         #4;
         if (rst) begin
            hold_v = 0;
         end else begin
            if (hold_v) begin
               total++;
               if (o_valid !== 1'b1 || o_gray !== hold_gray || o_565 !== hold_565) begin
                  bad++;
                  $display("FAIL stall_stable: got v=%b gray=%0d c565=%h, want v=1 gray=%0d c565=%h",
                           o_valid, o_gray, o_565, hold_gray, hold_565);
               end
            end
            if (o_valid && i_ready) begin
               total++;
               if (sb.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_out: got gray=%0d with empty scoreboard", o_gray);
               end else begin
                  e = sb.pop_front();
                  pop_cnt++;
                  pop_hist.push_back(cyc);
                  if (o_gray !== e.gray || o_565 !== e.c565) begin
                     bad++;
                     $display("FAIL data: got gray=%0d c565=%h, want gray=%0d c565=%h",
                              o_gray, o_565, e.gray, e.c565);
                  end
                  if (lat_chk) begin
                     total++;
                     if (cyc - e.acc != 3) begin
                        bad++;
                        $display("FAIL latency: got %0d cycles, want 3", cyc - e.acc);
                     end
                  end
               end
            end
            hold_v    = o_valid && !i_ready;
            hold_gray = o_gray;
            hold_565  = o_565;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   task automatic send(input int idx);
      int n;
      bit done;
      exp_t e;
      n    = 0;
      done = 0;
      @(negedge clk);
      i_rgb   = vec_rgb[idx];
      i_mode  = vec_mode[idx];
      i_valid = 1'b1;
      while (!done) begin
         #4;
         if (o_ready) begin
            e.gray = vec_gray[idx];
            e.c565 = pack565(vec_gray[idx]);
            e.acc  = cyc;
            sb.push_back(e);
            done = 1;
         end else if (n > 500) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no o_ready, want accept of vector %0d", idx);
            done = 1;
         end
         n++;
         @(posedge clk);
         if (!done) @(negedge clk);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      i_valid = 1'b0;
   endtask

   task automatic set_rdy(input int m);
      @(posedge clk);
      rdy_mode = m;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      check("drain_empty", sb.size(), 0);
   endtask

   initial begin : main
      int n0;
      int n;
      vec_rgb[0]  = 16'hFFFF; vec_mode[0]  = 2'd0; vec_gray[0]  = 8'd255;
      vec_rgb[1]  = 16'hF800; vec_mode[1]  = 2'd0; vec_gray[1]  = 8'd77;
      vec_rgb[2]  = 16'h001F; vec_mode[2]  = 2'd1; vec_gray[2]  = 8'd85;
      vec_rgb[3]  = 16'h001F; vec_mode[3]  = 2'd2; vec_gray[3]  = 8'd255;
      vec_rgb[4]  = 16'h07E0; vec_mode[4]  = 2'd3; vec_gray[4]  = 8'd255;
      vec_rgb[5]  = 16'h0000; vec_mode[5]  = 2'd3; vec_gray[5]  = 8'd0;
      vec_rgb[6]  = 16'h07E0; vec_mode[6]  = 2'd0; vec_gray[6]  = 8'd149;
      vec_rgb[7]  = 16'h001F; vec_mode[7]  = 2'd0; vec_gray[7]  = 8'd29;
      vec_rgb[8]  = 16'h8410; vec_mode[8]  = 2'd0; vec_gray[8]  = 8'd131;
      vec_rgb[9]  = 16'h8410; vec_mode[9]  = 2'd1; vec_gray[9]  = 8'd132;
      vec_rgb[10] = 16'h8410; vec_mode[10] = 2'd2; vec_gray[10] = 8'd132;
      vec_rgb[11] = 16'h8410; vec_mode[11] = 2'd3; vec_gray[11] = 8'd130;
      vec_rgb[12] = 16'hF800; vec_mode[12] = 2'd2; vec_gray[12] = 8'd255;
      vec_rgb[13] = 16'h0841; vec_mode[13] = 2'd0; vec_gray[13] = 8'd8;
      vec_rgb[14] = 16'h0841; vec_mode[14] = 2'd1; vec_gray[14] = 8'd8;
      vec_rgb[15] = 16'h1234; vec_mode[15] = 2'd0; vec_gray[15] = 8'd64;

      rgb4    = 16'hFFFF; mode4 = 2'd0;
      rgb8    = 24'h808080; mode8 = 2'd1;
      one     = 1'b1;
      rst     = 1'b1;
      i_valid = 1'b0;
      i_rgb   = '0;
      i_mode  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #4;
      check("reset_o_valid", 32'(o_valid), 32'd0);
      check("reset_o_gray", 32'(o_gray), 32'd0);
      check("reset_o_565", 32'(o_565), 32'd0);
      check("reset_o_ready", 32'(o_ready), 32'd1);

      // Isolated pixels, each with latency check
      lat_chk = 1;
      for (int i = 0; i < 16; i++) begin
         send(i);
         idle();
         repeat (6) @(posedge clk);
      end
      @(posedge clk);
      lat_chk = 0;

      // Back-to-back stream: 16 outputs on consecutive cycles
      n0 = pop_cnt;
      for (int i = 0; i < 16; i++) send(i);
      idle();
      n = 0;
      while (pop_cnt < n0 + 16 && n < 100) begin
         @(posedge clk);
         n++;
      end
      check("stream_count", pop_cnt - n0, 16);
      if (pop_cnt >= n0 + 16)
         check("stream_no_bubble", pop_hist[n0+15] - pop_hist[n0], 15);

      // Downstream stall for 5 cycles while streaming
      fork
         begin
            for (int i = 0; i < 12; i++) send(i);
            idle();
         end
         begin
            repeat (4) @(posedge clk);
            rdy_mode = 1;
            repeat (5) @(negedge clk);
            #4;
            check("stall_o_ready", 32'(o_ready), 32'd0);
            rdy_mode = 0;
         end
      join
      drain();

      // Random downstream readiness
      set_rdy(2);
      for (int i = 0; i < 32; i++) send(i % 16);
      idle();
      set_rdy(0);
      drain();

      // Reset with three pixels in flight
      set_rdy(1);
      for (int i = 0; i < 3; i++) send(i + 8);
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      sb.delete();
      n0 = pop_cnt;
      @(negedge clk);
      rst = 1'b0;
      #4;
      check("midrst_o_valid", 32'(o_valid), 32'd0);
      check("midrst_o_ready", 32'(o_ready), 32'd1);
      set_rdy(0);
      repeat (10) @(posedge clk);
      check("midrst_no_output", pop_cnt - n0, 0);

      // Parameter corner instances run continuously with constant input
      @(negedge clk);
      #4;
      check("outw4_valid", 32'(val4_o), 32'd1);
      check("outw4_gray", 32'(gray4), 32'hF);
      check("outw4_565", 32'(c565_4), 32'hFFFF);
      check("w8_avg_gray", 32'(gray8), 32'd128);
      check("w8_avg_565", 32'(c565_8), 32'h8410);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rgb_to_gray_stream.md
RGB_TO_GRAY_STREAM -- requirements
Module: rgb_to_gray_stream

Interface
REQ-001 SHALL have parameter R_W, default 5, red field width in bits (4..8).
REQ-002 SHALL have parameter G_W, default 6, green field width in bits (4..8).
REQ-003 SHALL have parameter B_W, default 5, blue field width in bits (4..8).
REQ-004 SHALL have parameter OUT_W, default 8, gray output width in bits (1..8).
REQ-005 SHALL have port i_clk, input, 1, the only clock; all logic on its rising edge.
REQ-006 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port i_rgb, input, R_W+G_W+B_W, packed pixel {R,G,B}, R in the MSBs.
REQ-008 SHALL have port i_mode, input, 2, conversion mode sampled with each pixel.
REQ-009 SHALL have port i_valid, input, 1, upstream pixel valid.
REQ-010 SHALL have port o_ready, output, 1, block accepts a pixel this cycle.
REQ-011 SHALL have port o_gray, output, OUT_W, gray result.
REQ-012 SHALL have port o_gray_rgb565, output, 16, gray result re-packed as RGB565.
REQ-013 SHALL have port o_valid, output, 1, output pixel valid.
REQ-014 SHALL have port i_ready, input, 1, downstream accepts output.

Function
REQ-015 SHALL transfer a pixel in only when i_valid and o_ready are both 1 in the same cycle; i_mode travels with that pixel.
REQ-016 SHALL transfer a pixel out only when o_valid and i_ready are both 1; o_gray, o_gray_rgb565 and o_valid SHALL stay stable while o_valid=1 and i_ready=0.
REQ-017 SHALL be a 3-stage registered pipeline (S1 expand, S2 multiply/compare, S3 round/pack); latency 3 cycles from input handshake to o_valid with i_ready held at 1.
REQ-018 SHALL sustain one pixel per cycle when i_valid=1 and i_ready=1 continuously.
REQ-019 SHALL advance each stage when the stage is empty or the next stage advances (bubble collapse); o_ready = S1 empty or S1 advancing; a combinational path from i_ready to o_ready is permitted.
REQ-020 SHALL never drop, duplicate or reorder pixels under any i_valid/i_ready pattern.
REQ-021 SHALL expand each channel to 8 bits in S1 by MSB replication: {x, x[W-1 -: 8-W]}, identity when W=8 (0x1F->0xFF, 0x00->0x00).
REQ-022 i_mode=0 (luma): g8 = (77*r8 + 150*g8 + 29*b8 + 128) >> 8, 17-bit sum, no overflow.
REQ-023 i_mode=1 (average): g8 = ((r8+g8+b8)*171 + 256) >> 9, 18-bit intermediate.
REQ-024 i_mode=2 (max): g8 = max(r8, g8, b8).
REQ-025 i_mode=3 (green): g8 = expanded green channel.
REQ-026 SHALL saturate any g8 result above 255 to 255.
REQ-027 o_gray SHALL equal g8[7 -: OUT_W] (truncation).
REQ-028 o_gray_rgb565 SHALL equal {g8[7:3], g8[7:2], g8[7:3]}.
REQ-029 A change of i_mode between pixels SHALL affect only pixels accepted after the change.

Reset
REQ-030 While i_rst=1, all stage valid flags SHALL clear on the clock edge; o_valid=0 from the next cycle.
REQ-031 After reset, o_gray=0, o_gray_rgb565=0x0000, o_ready=1.
REQ-032 Reset mid-stream SHALL discard all in-flight pixels; no pixel accepted before or during reset SHALL appear afterward.
REQ-033 Handshakes SHALL be ignored while i_rst=1.

Verification
REQ-034 Default params, mode 0: i_rgb=0xFFFF -> o_gray=255, o_gray_rgb565=0xFFFF, 3 cycles after accept; 0xF800 -> 77, 0x4A69.
REQ-035 Mode 1: 0x001F -> 85; mode 2: 0x001F -> 255; mode 3: 0x07E0 -> 255, 0x0000 -> 0.
REQ-036 Back-to-back stream of 16 pixels with i_ready=1 -> 16 consecutive o_valid cycles, in order, zero bubbles.
REQ-037 i_ready=0 for 5 cycles while streaming -> o_ready=0 after the pipeline fills (3 pixels held), outputs stable, then all pixels delivered in order once i_ready=1.
REQ-038 i_rst pulsed with 3 pixels in flight -> o_valid=0 next cycle, none of the 3 emitted later.
REQ-039 OUT_W=4, mode 0, 0xFFFF -> o_gray=0xF; R_W=G_W=B_W=8, 0x808080 mode 1 -> 128.
